// File: rtl/sram_march_bist_ctrl.sv
// March C- BIST sequencer driving one port of the 512x8 byte-mask SRAM macro.
// Issues one access per cycle, checks read data two edges later and records the first failure.
module sram_march_bist_ctrl #(
  parameter int                DATA_W     = 8,
  parameter int                ADDR_W     = 9,
  parameter logic [DATA_W-1:0] BACKGROUND = '0,
  parameter int                ERRCNT_W   = 16
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                START,
  input  logic [DATA_W-1:0]   DOUT,
  output logic                BIST_EN,
  output logic                BIST_MEN,
  output logic                BIST_WEN,
  output logic                BIST_REN,
  output logic [ADDR_W-1:0]   BIST_ADDR,
  output logic [DATA_W-1:0]   BIST_DIN,
  output logic [DATA_W-1:0]   BIST_BM,
  output logic                BUSY,
  output logic                DONE,
  output logic                FAIL,
  output logic [ADDR_W-1:0]   FAIL_ADDR,
  output logic [2:0]          FAIL_ELEM,
  output logic [DATA_W-1:0]   FAIL_DATA,
  output logic [ERRCNT_W-1:0] ERR_CNT
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t              state;
  logic [2:0]          cur_elem;
  logic                cur_op;
  logic [ADDR_W-1:0]   cur_addr;

  logic [2:0]          nxt_elem;
  logic                nxt_op;
  logic [ADDR_W-1:0]   nxt_addr;
  logic                seq_end;
  logic                two_ops;
  logic                down;
  logic                elem_last_addr;

  logic                issue;
  logic [2:0]          acc_elem;
  logic                acc_op;
  logic [ADDR_W-1:0]   acc_addr;
  logic                acc_read;
  logic [DATA_W-1:0]   acc_exp;
  logic [DATA_W-1:0]   acc_wdata;

  logic                p1_v, p2_v;
  logic [DATA_W-1:0]   p1_exp, p2_exp;
  logic [ADDR_W-1:0]   p1_addr, p2_addr;
  logic [2:0]          p1_elem, p2_elem;

  // Step the (element, op, address) pointer of the access currently on the bus.
  always_comb begin
    two_ops        = (cur_elem != 3'd0) && (cur_elem != 3'd5);
    down           = (cur_elem == 3'd3) || (cur_elem == 3'd4);
    elem_last_addr = down ? (cur_addr == '0) : (cur_addr == ADDR_MAX);
    nxt_elem       = cur_elem;
    nxt_op         = 1'b0;
    nxt_addr       = cur_addr;
    seq_end        = 1'b0;
    if (two_ops && !cur_op) begin
      nxt_op = 1'b1;
    end else if (elem_last_addr) begin
      if (cur_elem == 3'd5) begin
        seq_end = 1'b1;
      end else begin
        nxt_elem = cur_elem + 3'd1;
        nxt_addr = ((cur_elem + 3'd1 == 3'd3) || (cur_elem + 3'd1 == 3'd4)) ? ADDR_MAX : '0;
      end
    end else begin
      nxt_addr = down ? (cur_addr - ADDR_ONE) : (cur_addr + ADDR_ONE);
    end
  end

  // The access to register this edge: the first one on START, otherwise the next in sequence.
  always_comb begin
    issue     = 1'b0;
    acc_elem  = 3'd0;
    acc_op    = 1'b0;
    acc_addr  = '0;
    if (state == S_RUN) begin
      issue    = !seq_end;
      acc_elem = nxt_elem;
      acc_op   = nxt_op;
      acc_addr = nxt_addr;
    end else if ((state == S_IDLE) || (state == S_DONE)) begin
      issue = START;
    end
    acc_read  = (acc_elem != 3'd0) && !acc_op;
    acc_exp   = ((acc_elem == 3'd2) || (acc_elem == 3'd4)) ? ~BACKGROUND : BACKGROUND;
    acc_wdata = ((acc_elem == 3'd1) || (acc_elem == 3'd3)) ? ~BACKGROUND : BACKGROUND;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      cur_elem  <= 3'd0;
      cur_op    <= 1'b0;
      cur_addr  <= '0;
      BIST_EN   <= 1'b0;
      BIST_MEN  <= 1'b0;
      BIST_WEN  <= 1'b0;
      BIST_REN  <= 1'b0;
      BIST_ADDR <= '0;
      BIST_DIN  <= '0;
      BIST_BM   <= '0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      FAIL      <= 1'b0;
      FAIL_ADDR <= '0;
      FAIL_ELEM <= 3'd0;
      FAIL_DATA <= '0;
      ERR_CNT   <= '0;
      p1_v      <= 1'b0;
      p1_exp    <= '0;
      p1_addr   <= '0;
      p1_elem   <= 3'd0;
      p2_v      <= 1'b0;
      p2_exp    <= '0;
      p2_addr   <= '0;
      p2_elem   <= 3'd0;
    end else begin
      // Two-stage compare pipeline: macro samples the read one edge later, DOUT is checked the next.
      p1_v    <= issue && acc_read;
      p1_exp  <= acc_exp;
      p1_addr <= acc_addr;
      p1_elem <= acc_elem;
      p2_v    <= p1_v;
      p2_exp  <= p1_exp;
      p2_addr <= p1_addr;
      p2_elem <= p1_elem;

      if (p2_v && (DOUT != p2_exp)) begin
        FAIL <= 1'b1;
        if (ERR_CNT != '1) ERR_CNT <= ERR_CNT + ERRCNT_W'(1);
        if (!FAIL) begin
          FAIL_ADDR <= p2_addr;
          FAIL_ELEM <= p2_elem;
          FAIL_DATA <= DOUT ^ p2_exp;
        end
      end

      BIST_MEN  <= 1'b0;
      BIST_WEN  <= 1'b0;
      BIST_REN  <= 1'b0;
      BIST_ADDR <= '0;
      BIST_DIN  <= '0;
      BIST_BM   <= '0;
      if (issue) begin
        BIST_MEN  <= 1'b1;
        BIST_WEN  <= !acc_read;
        BIST_REN  <= acc_read;
        BIST_ADDR <= acc_addr;
        BIST_DIN  <= acc_read ? '0 : acc_wdata;
        BIST_BM   <= acc_read ? '0 : '1;
        cur_elem  <= acc_elem;
        cur_op    <= acc_op;
        cur_addr  <= acc_addr;
      end

      case (state)
        S_IDLE, S_DONE: begin
          if (START) begin
            state     <= S_RUN;
            BUSY      <= 1'b1;
            BIST_EN   <= 1'b1;
            DONE      <= 1'b0;
            FAIL      <= 1'b0;
            FAIL_ADDR <= '0;
            FAIL_ELEM <= 3'd0;
            FAIL_DATA <= '0;
            ERR_CNT   <= '0;
          end
        end
        S_RUN: begin
          if (seq_end) state <= S_DRAIN;
        end
        S_DRAIN: begin
          state   <= S_DONE;
          BUSY    <= 1'b0;
          BIST_EN <= 1'b0;
          DONE    <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_march_bist_ctrl.sv
// Directed bench for sram_march_bist_ctrl: three instances (default, BACKGROUND=0x55,
// ERRCNT_W=2) each attached to a small behavioural memory model.
module tb_sram_march_bist_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic start0, start_aux;
  logic fault0;

  int n_checks = 0;
  int n_errors = 0;
  int wr_cnt, rd_cnt, bus_bad;

  // Instance 0: default parameters
  logic [7:0]  dout0;
  logic        en0, men0, wen0, ren0, busy0, done0, fail0;
  logic [8:0]  addr0, fail_addr0;
  logic [7:0]  din0, bm0, fail_data0;
  logic [2:0]  fail_elem0;
  logic [15:0] err_cnt0;

  // Instance 1: BACKGROUND = 0x55
  logic [7:0]  dout1;
  logic        en1, men1, wen1, ren1, busy1, done1, fail1;
  logic [8:0]  addr1, fail_addr1;
  logic [7:0]  din1, bm1, fail_data1;
  logic [2:0]  fail_elem1;
  logic [15:0] err_cnt1;

  // Instance 2: ERRCNT_W = 2, memory always reads 0xFF
  logic [7:0]  dout2;
  logic        en2, men2, wen2, ren2, busy2, done2, fail2;
  logic [8:0]  addr2, fail_addr2;
  logic [7:0]  din2, bm2, fail_data2;
  logic [2:0]  fail_elem2;
  logic [1:0]  err_cnt2;

  logic [7:0] mem0 [512];
  logic [7:0] mem1 [512];

  assign dout2 = 8'hFF;

  always #5 clk = ~clk;

  sram_march_bist_ctrl dut0 (
    .CLK(clk), .RST(rst), .START(start0), .DOUT(dout0),
    .BIST_EN(en0), .BIST_MEN(men0), .BIST_WEN(wen0), .BIST_REN(ren0),
    .BIST_ADDR(addr0), .BIST_DIN(din0), .BIST_BM(bm0),
    .BUSY(busy0), .DONE(done0), .FAIL(fail0), .FAIL_ADDR(fail_addr0),
    .FAIL_ELEM(fail_elem0), .FAIL_DATA(fail_data0), .ERR_CNT(err_cnt0)
  );

  sram_march_bist_ctrl #(.BACKGROUND(8'h55)) dut1 (
    .CLK(clk), .RST(rst), .START(start_aux), .DOUT(dout1),
    .BIST_EN(en1), .BIST_MEN(men1), .BIST_WEN(wen1), .BIST_REN(ren1),
    .BIST_ADDR(addr1), .BIST_DIN(din1), .BIST_BM(bm1),
    .BUSY(busy1), .DONE(done1), .FAIL(fail1), .FAIL_ADDR(fail_addr1),
    .FAIL_ELEM(fail_elem1), .FAIL_DATA(fail_data1), .ERR_CNT(err_cnt1)
  );

  sram_march_bist_ctrl #(.ERRCNT_W(2)) dut2 (
    .CLK(clk), .RST(rst), .START(start_aux), .DOUT(dout2),
    .BIST_EN(en2), .BIST_MEN(men2), .BIST_WEN(wen2), .BIST_REN(ren2),
    .BIST_ADDR(addr2), .BIST_DIN(din2), .BIST_BM(bm2),
    .BUSY(busy2), .DONE(done2), .FAIL(fail2), .FAIL_ADDR(fail_addr2),
    .FAIL_ELEM(fail_elem2), .FAIL_DATA(fail_data2), .ERR_CNT(err_cnt2)
  );

  // Behavioural macro ports; fault0 forces bit 3 of address 0x07A to read as 1.
  always @(posedge clk) begin
    if (men0 && wen0) mem0[addr0] <= (mem0[addr0] & ~bm0) | (din0 & bm0);
    if (men0 && ren0) dout0 <= mem0[addr0] | ((fault0 && addr0 == 9'h07A) ? 8'h08 : 8'h00);
    if (men1 && wen1) mem1[addr1] <= (mem1[addr1] & ~bm1) | (din1 & bm1);
    if (men1 && ren1) dout1 <= mem1[addr1];
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic any_out0();
    return en0 | men0 | wen0 | ren0 | (|addr0) | (|din0) | (|bm0) | busy0 | done0 |
           fail0 | (|fail_addr0) | (|fail_elem0) | (|fail_data0) | (|err_cnt0);
  endfunction

  // Start a test at edge k and observe cycles k+1..k+5122 at the falling edge.
  task automatic run_test(input bit with_aux, input int repulse_at, input int rst_at);
    wr_cnt  = 0;
    rd_cnt  = 0;
    bus_bad = 0;
    @(negedge clk);
    start0    = 1'b1;
    start_aux = with_aux;
    @(negedge clk);
    start0    = 1'b0;
    start_aux = 1'b0;
    for (int cyc = 1; cyc <= 5122; cyc++) begin
      if (cyc > 1) @(negedge clk);
      start0 = (cyc == repulse_at);
      if (cyc == rst_at) begin
        rst = 1'b1;
        break;
      end
      if (men0 && wen0) wr_cnt++;
      if (men0 && ren0) rd_cnt++;
      if ((men0 && (wen0 == ren0)) ||
          (wen0 && bm0 != 8'hFF) || (ren0 && (bm0 != 8'h00 || din0 != 8'h00)) ||
          (!men0 && (wen0 || ren0 || addr0 != 9'h0 || din0 != 8'h0 || bm0 != 8'h0)))
        bus_bad++;
      if (cyc == 1) begin
        check("first_wen", 32'(wen0), 32'h1);
        check("first_addr", 32'(addr0), 32'h000);
        check("first_din", 32'(din0), 32'h00);
        check("first_en", 32'(en0), 32'h1);
      end
      if (cyc == 5121) begin
        check("drain_busy", 32'(busy0), 32'h1);
        check("drain_done", 32'(done0), 32'h0);
        check("drain_men", 32'(men0), 32'h0);
      end
      if (cyc == 5122) begin
        check("end_busy", 32'(busy0), 32'h0);
        check("end_done", 32'(done0), 32'h1);
        check("end_en", 32'(en0), 32'h0);
      end
      if (with_aux) begin
        if (cyc == 1) check("bg55_e0_din", 32'({wen1, din1}), 32'h155);
        if (cyc == 514) check("bg55_e1_din", 32'({wen1, din1}), 32'h1AA);
        if (cyc == 2561) check("bg55_e3_first", 32'({ren1, addr1}), 32'h3FF);
        if (cyc == 2000) check("sat_mid", 32'(err_cnt2), 32'h3);
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    start0    = 1'b0;
    start_aux = 1'b0;
    fault0    = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outs", 32'(any_out0()), 32'h0);
    rst = 1'b0;

    // Fault-free run on all three instances
    run_test(1'b1, 0, 0);
    check("clean_writes", 32'(wr_cnt), 32'd2560);
    check("clean_reads", 32'(rd_cnt), 32'd2560);
    check("clean_bus", 32'(bus_bad), 32'd0);
    check("clean_fail", 32'(fail0), 32'h0);
    check("clean_errcnt", 32'(err_cnt0), 32'h0);
    check("bg55_done", 32'(done1), 32'h1);
    check("bg55_fail", 32'(fail1), 32'h0);
    check("sat_errcnt", 32'(err_cnt2), 32'h3);
    check("sat_fail", 32'(fail2), 32'h1);
    check("sat_elem", 32'(fail_elem2), 32'h1);
    check("sat_addr", 32'(fail_addr2), 32'h000);
    check("sat_data", 32'(fail_data2), 32'hFF);

    // Stuck-at-1 on bit 3 of 0x07A, with START re-pulsed at k+100
    fault0 = 1'b1;
    run_test(1'b0, 100, 0);
    check("stuck_fail", 32'(fail0), 32'h1);
    check("stuck_elem", 32'(fail_elem0), 32'h1);
    check("stuck_addr", 32'(fail_addr0), 32'h07A);
    check("stuck_data", 32'(fail_data0), 32'h08);
    check("stuck_errcnt", 32'(err_cnt0), 32'h3);

    // Reset at k+3000 aborts the test
    fault0 = 1'b0;
    run_test(1'b0, 0, 3000);
    @(negedge clk);
    check("abort_outs", 32'(any_out0()), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_idle_done", 32'(done0), 32'h0);

    // Full clean run after the abort
    run_test(1'b0, 0, 0);
    check("rerun_writes", 32'(wr_cnt), 32'd2560);
    check("rerun_reads", 32'(rd_cnt), 32'd2560);
    check("rerun_bus", 32'(bus_bad), 32'd0);
    check("rerun_fail", 32'(fail0), 32'h0);
    check("rerun_errcnt", 32'(err_cnt0), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sram_march_bist_ctrl.md
Name: sram_march_bist_ctrl

Overview:
- Single-port March C- BIST sequencer for one port of the 2-port 512x8 byte-mask SRAM macro.
- It drives that port's BIST_* input group (EN/MEN/WEN/REN/ADDR/DIN/BM) and consumes the port's DOUT for comparison.
- It reports done/fail status plus first-failure diagnostics to the DFT/test controller.
- One instance is used per SRAM port (A or B).

Parameters:
- DATA_W, 8, data/mask width; equals the macro word width.
- ADDR_W, 9, address width; depth is 2**ADDR_W (512).
- BACKGROUND, 8'h00, data pattern for "0" ops; "1" ops use ~BACKGROUND.
- ERRCNT_W, 16, width of the saturating error counter.

Ports:
- CLK  in  1  BIST clock; the same net drives the macro's x_BIST_CLK.
- RST  in  1  synchronous active-high reset.
- START  in  1  start request; sampled only in IDLE or DONE state.
- DOUT  in  DATA_W  macro read data for this port; valid the cycle after a read edge.
- BIST_EN  out  1  selects the macro's BIST interface; high while BUSY.
- BIST_MEN  out  1  memory enable.
- BIST_WEN  out  1  write enable.
- BIST_REN  out  1  read enable.
- BIST_ADDR  out  ADDR_W  access address.
- BIST_DIN  out  DATA_W  write data.
- BIST_BM  out  DATA_W  bit mask; all ones during writes, 0 otherwise.
- BUSY  out  1  test in progress.
- DONE  out  1  test finished; held until the next accepted START or RST.
- FAIL  out  1  sticky; at least one miscompare seen.
- FAIL_ADDR  out  ADDR_W  address of the first miscompare.
- FAIL_ELEM  out  3  March element index (0-5) of the first miscompare.
- FAIL_DATA  out  DATA_W  DOUT XOR expected at the first miscompare.
- ERR_CNT  out  ERRCNT_W  saturating miscompare count.

Behaviour:
- Clocking: single clock CLK. Synchronous active-high reset RST. All outputs are registered.
- Reset: all outputs 0, state IDLE.
- Reset mid-test: the sequence aborts. BIST_EN/MEN/WEN/REN fall at the RST edge. No DONE is produced.
- States: IDLE -> RUN -> DRAIN -> DONE.
  - IDLE --START--> RUN
  - RUN --last op of element 5 issued--> DRAIN
  - DRAIN --1 cycle--> DONE
  - DONE --START--> RUN
- Accepting START clears FAIL, FAIL_*, ERR_CNT and DONE.
- START is ignored while in RUN or DRAIN.
- March C- elements (D = BACKGROUND, ~D its inverse):
  - E0 up(w D)
  - E1 up(r D, w ~D)
  - E2 up(r ~D, w D)
  - E3 down(r D, w ~D)
  - E4 down(r ~D, w D)
  - E5 up(r D)
- "up" runs addresses 0..DEPTH-1; "down" runs DEPTH-1..0.
- Within an element, all ops are applied to one address before the address advances.
- Exactly one access per RUN cycle, back-to-back with no bubbles: 10*DEPTH = 5120 access cycles.
- Write cycle: MEN=1, WEN=1, REN=0, BM=all ones, DIN=pattern.
- Read cycle: MEN=1, REN=1, WEN=0, BM=0, DIN=0.
- Outside RUN: MEN/WEN/REN=0, ADDR=0, DIN=0, BM=0.
- Timing from the edge k at which START is accepted:
  - Access n (0-based) is driven during cycle k+1+n.
  - BUSY and BIST_EN are high for cycles k+1..k+5121; cycle k+5121 is DRAIN.
  - DONE is high from cycle k+5122.
- Compare pipeline: a read driven in cycle c is clocked by the macro at edge c+1. DOUT is compared at edge c+2 against the expected data, address and element registered alongside the read. The last read's compare happens at the DRAIN exit edge.
- On miscompare:
  - ERR_CNT increments, saturating at 2**ERRCNT_W-1.
  - FAIL is set.
  - FAIL_ADDR/FAIL_ELEM/FAIL_DATA are loaded only if FAIL was 0, so the first failure wins.
- Address counter: wraps only at element boundaries. The last address of an element is DEPTH-1 (up) or 0 (down). No extra cycle is spent between elements.
- Element index is 3 bits; values 6-7 are unreachable.

Test Plan:
- Fault-free behavioural memory, START at edge k:
  - Exactly 2560 write and 2560 read cycles.
  - First access is a write of 0x00 to addr 0 in cycle k+1.
  - BUSY falls and DONE rises at cycle k+5122; FAIL=0, ERR_CNT=0.
- Bit 3 of addr 0x07A stuck at 1, BACKGROUND=0x00:
  - FAIL=1, FAIL_ELEM=1, FAIL_ADDR=0x07A, FAIL_DATA=0x08.
  - ERR_CNT=3 (E1, E3, E5 reads).
- ERRCNT_W=2, memory model whose reads always return 0xFF:
  - ERR_CNT saturates at 3 and stays there.
  - FAIL_ELEM=1, FAIL_ADDR=0x000, FAIL_DATA=0xFF.
- START re-pulsed at cycle k+100 during RUN:
  - Ignored; the sequence completes at k+5122 unchanged.
- RST asserted at cycle k+3000:
  - At the next edge all outputs are 0 and the state is IDLE.
  - A new START then runs a full, clean test.
- BACKGROUND=0x55, fault-free:
  - E0 writes 0x55 and E1 writes 0xAA.
  - E3 first access is a read at addr 0x1FF; test passes.
